// File: rtl/uart_pkg.sv
// Shared UART definitions: state encoding, frame constants and baud arithmetic.
// Used by both uart_rx and uart_tx so the two ends agree on bit timing.
package uart_pkg;

  localparam int DATA_BITS = 8;
  localparam logic IDLE_LEVEL = 1'b1;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    WAIT_HIGH
  } uart_state_t;

  function automatic int bit_period(input int clk_freq, input int baud);
    return clk_freq / baud;
  endfunction

endpackage

// File: rtl/uart_rx_if.sv
// Receiver-side bundle: serial line in, byte/status out toward host logic.
// master = receiver, slave = the line driver plus host consumer.
interface uart_rx_if;
  import uart_pkg::*;

  logic                 rx;
  logic [DATA_BITS-1:0] rx_data;
  logic                 rx_valid;
  logic                 rx_busy;
  logic                 frame_err;
  logic                 parity_err;

  modport master (
    input  rx,
    output rx_data,
    output rx_valid,
    output rx_busy,
    output frame_err,
    output parity_err
  );

  modport slave (
    output rx,
    input  rx_data,
    input  rx_valid,
    input  rx_busy,
    input  frame_err,
    input  parity_err
  );

endinterface

// File: rtl/uart_rx_sync.sv
// Two-flop synchroniser for the asynchronous rx pin; 2-cycle latency, no backpressure.
// Both flops reset to the idle line level so reset never looks like a start bit.
module uart_rx_sync
  import uart_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic d,
  output logic q
);

  logic meta;

  always_ff @(posedge clk) begin
    if (rst) begin
      meta <= IDLE_LEVEL;
      q    <= IDLE_LEVEL;
    end else begin
      meta <= d;
      q    <= meta;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// 8N1 UART receiver, mid-bit sampling; rx_valid ~3+HALF_PERIOD+9*BIT_PERIOD clocks after start edge, no backpressure.
// Define UART_RX_PARITY_EN to expect an even-parity bit between data and stop.
module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 50000000,
  parameter int BAUD_RATE = 9600
) (
  input  logic      clk,
  input  logic      rst,
  uart_rx_if.master bus
);

  // BIT_PERIOD must be at least 4 for the half-period start check to be meaningful.
  localparam int BIT_PERIOD  = bit_period(CLK_FREQ, BAUD_RATE);
  localparam int HALF_PERIOD = BIT_PERIOD / 2;
  localparam int CNT_W       = $clog2(BIT_PERIOD);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_PERIOD - 1);
  localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(HALF_PERIOD - 1);
  localparam logic [2:0]       IDX_LAST = 3'(DATA_BITS - 1);

  logic rx_s;

  uart_rx_sync u_sync (
    .clk (clk),
    .rst (rst),
    .d   (bus.rx),
    .q   (rx_s)
  );

  uart_state_t          state,     state_nxt;
  logic [CNT_W-1:0]     cnt,       cnt_nxt;
  logic [2:0]           bit_idx,   bit_idx_nxt;
  logic [DATA_BITS-1:0] shift_reg, shift_nxt;
  logic [DATA_BITS-1:0] data_r,    data_nxt;
  logic                 valid_r,   valid_nxt;
  logic                 ferr_r,    ferr_nxt;
  logic                 busy_r,    busy_nxt;
`ifdef UART_RX_PARITY_EN
  logic                 par_r,     par_nxt;
  logic                 perr_r,    perr_nxt;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cnt       <= '0;
      bit_idx   <= '0;
      shift_reg <= '0;
      data_r    <= '0;
      valid_r   <= 1'b0;
      ferr_r    <= 1'b0;
      busy_r    <= 1'b0;
`ifdef UART_RX_PARITY_EN
      par_r     <= 1'b0;
      perr_r    <= 1'b0;
`endif
    end else begin
      state     <= state_nxt;
      cnt       <= cnt_nxt;
      bit_idx   <= bit_idx_nxt;
      shift_reg <= shift_nxt;
      data_r    <= data_nxt;
      valid_r   <= valid_nxt;
      ferr_r    <= ferr_nxt;
      busy_r    <= busy_nxt;
`ifdef UART_RX_PARITY_EN
      par_r     <= par_nxt;
      perr_r    <= perr_nxt;
`endif
    end
  end

  always_comb begin
    state_nxt   = state;
    cnt_nxt     = (cnt == CNT_LAST) ? '0 : cnt + 1'b1;
    bit_idx_nxt = bit_idx;
    shift_nxt   = shift_reg;
    data_nxt    = data_r;
    valid_nxt   = 1'b0;
    ferr_nxt    = 1'b0;
`ifdef UART_RX_PARITY_EN
    par_nxt     = par_r;
    perr_nxt    = 1'b0;
`endif

    case (state)
      IDLE: begin
        cnt_nxt = '0;
        if (!rx_s) state_nxt = START;
      end
      START: begin
        // Re-check the line halfway into the start bit to reject glitches.
        if (cnt == CNT_HALF) begin
          cnt_nxt     = '0;
          bit_idx_nxt = '0;
          state_nxt   = rx_s ? IDLE : DATA;
        end
      end
      DATA: begin
        if (cnt == CNT_LAST) begin
          shift_nxt   = {rx_s, shift_reg[DATA_BITS-1:1]};
          bit_idx_nxt = bit_idx + 3'd1;
`ifdef UART_RX_PARITY_EN
          if (bit_idx == IDX_LAST) state_nxt = PARITY;
`else
          if (bit_idx == IDX_LAST) state_nxt = STOP;
`endif
        end
      end
`ifdef UART_RX_PARITY_EN
      PARITY: begin
        if (cnt == CNT_LAST) begin
          par_nxt   = rx_s;
          state_nxt = STOP;
        end
      end
`endif
      STOP: begin
        // Leaving mid-stop-bit lets a back-to-back start edge be caught.
        if (cnt == CNT_LAST) begin
          if (rx_s) begin
            data_nxt  = shift_reg;
            valid_nxt = 1'b1;
`ifdef UART_RX_PARITY_EN
            perr_nxt  = ^{shift_reg, par_r};
`endif
            state_nxt = IDLE;
          end else begin
            ferr_nxt  = 1'b1;
            state_nxt = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        cnt_nxt = '0;
        if (rx_s) state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase

    busy_nxt = (state_nxt != IDLE);
  end

  assign bus.rx_data   = data_r;
  assign bus.rx_valid  = valid_r;
  assign bus.rx_busy   = busy_r;
  assign bus.frame_err = ferr_r;
`ifdef UART_RX_PARITY_EN
  assign bus.parity_err = perr_r;
`else
  assign bus.parity_err = 1'b0;
`endif

endmodule
